ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_pkg.sv | 99 +++++++++
 rtl/alu_op_dec.sv | 38 +++
 rtl/ctrl_fsm.sv | 155 +++++++++++++++
 tb/tb_ctrl_fsm.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ctrl_fsm control unit: FSM states, ALU operations,
// opcode/funct3 constants, instruction classes and the datapath control bundle.
package ctrl_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned STATUS_W = 5;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned IMMSEL_W = 2;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned ICLASS_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } aluop_t;

  typedef enum logic [ICLASS_W-1:0] {
    IC_R,
    IC_IALU,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_ILLEGAL
  } iclass_t;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT = 3'b010;
  localparam logic [F3_W-1:0] F3_XOR = 3'b100;
  localparam logic [F3_W-1:0] F3_SRL = 3'b101;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [IMMSEL_W-1:0] IMM_I = 2'b00;
  localparam logic [IMMSEL_W-1:0] IMM_S = 2'b01;
  localparam logic [IMMSEL_W-1:0] IMM_B = 2'b10;

  localparam logic ALUSRC_IMM = 1'b0;
  localparam logic ALUSRC_REG = 1'b1;
  localparam logic WB_RAM     = 1'b0;
  localparam logic WB_ALU     = 1'b1;

  typedef struct packed {
    logic                pcsrc;
    logic                alusrc;
    logic                memrw;
    logic                wb;
    logic                regrw;
    logic [ALUOP_W-1:0]  aluop;
    logic [IMMSEL_W-1:0] immgen_ctrl;
    logic                pc_en;
  } ctrl_t;

  function automatic iclass_t classify(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OPC_R:      return IC_R;
      OPC_IALU:   return IC_IALU;
      OPC_LOAD:   return IC_LOAD;
      OPC_STORE:  return IC_STORE;
      OPC_BRANCH: return IC_BRANCH;
      default:    return IC_ILLEGAL;
    endcase
  endfunction

  // R-type has no immediate; its selector is left at the I encoding.
  function automatic logic [IMMSEL_W-1:0] imm_sel(input iclass_t iclass);
    case (iclass)
      IC_STORE:  return IMM_S;
      IC_BRANCH: return IMM_B;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// ALU operation decode from instruction class, funct3 and funct7 bit 5;
// also flags funct3 values that have no mapping for the class.
module alu_op_dec
  import ctrl_pkg::*;
(
  input  iclass_t         iclass,
  input  logic [F3_W-1:0] funct3,
  input  logic            funct7_b5,
  output aluop_t          aluop_c,
  output logic            funct_ok_c
);

  always_comb begin
    aluop_c    = ALU_ADD;
    funct_ok_c = 1'b1;
    case (iclass)
      IC_R, IC_IALU: begin
        case (funct3)
          F3_ADD:  aluop_c = (iclass == IC_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          F3_SLL:  aluop_c = ALU_SLL;
          F3_SLT:  aluop_c = ALU_SLT;
          F3_XOR:  aluop_c = ALU_XOR;
          F3_SRL:  aluop_c = ALU_SRL;
          F3_OR:   aluop_c = ALU_OR;
          F3_AND:  aluop_c = ALU_AND;
          default: funct_ok_c = 1'b0;  // 011 (unsigned compare) is not supported
        endcase
      end
      IC_LOAD, IC_STORE: aluop_c = ALU_ADD;
      IC_BRANCH: begin
        aluop_c    = ALU_SUB;
        funct_ok_c = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      default: funct_ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB, sticky TRAP) with retired counter.
// Define CTRL_PARITY_CHECK_EN to trap in DECODE when ^ir disagrees with status[4].
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [STATUS_W-1:0] status,
  output logic                pcsrc,
  output logic                alusrc,
  output logic                memrw,
  output logic                wb,
  output logic                regrw,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [IMMSEL_W-1:0] immgen_ctrl,
  output logic                pc_en,
  output logic [STATE_W-1:0]  state,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_q;
  state_t              state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [RETIRE_W-1:0] retired_q;
  iclass_t             iclass;
  aluop_t              aluop_dec;
  logic [F3_W-1:0]     funct3;
  logic                funct_ok;
  logic                parity_ok;
  logic                decode_ok;
  logic                zero;
  logic                in_instr;
  ctrl_t               ctrl;
  logic                unused_status;
  logic                unused_ir;

  assign iclass   = classify(ir_q[OPC_W-1:0]);
  assign funct3   = ir_q[14:12];
  assign zero     = status[0];
  assign in_instr = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  alu_op_dec u_alu_op_dec (
    .iclass     (iclass),
    .funct3     (funct3),
    .funct7_b5  (ir_q[30]),
    .aluop_c    (aluop_dec),
    .funct_ok_c (funct_ok)
  );

`ifdef CTRL_PARITY_CHECK_EN
  assign parity_ok     = ((^ir_q) == status[4]);
  assign unused_status = ^status[3:1];
`else
  assign parity_ok     = 1'b1;
  assign unused_status = ^status[4:1];
`endif
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign decode_ok = (iclass != IC_ILLEGAL) && funct_ok && parity_ok;

  // State register; rst wins over every transition including TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register and retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      if (state_q == ST_FETCH) begin
        ir_q <= instr;
      end
      if (ctrl.pc_en) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  // Next state and datapath controls.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;

    // Operand/ALU selection is held constant for the whole execute phase.
    if (in_instr) begin
      ctrl.aluop       = aluop_dec;
      ctrl.alusrc      = (iclass == IC_R || iclass == IC_BRANCH) ? ALUSRC_REG : ALUSRC_IMM;
      ctrl.immgen_ctrl = imm_sel(iclass);
    end

    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = decode_ok ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (iclass)
          IC_R, IC_IALU:     state_d = ST_WB;
          IC_LOAD, IC_STORE: state_d = ST_MEM;
          IC_BRANCH: begin
            state_d    = ST_FETCH;
            ctrl.pcsrc = (funct3 == F3_BNE) ? ~zero : zero;
            ctrl.pc_en = 1'b1;
          end
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (iclass == IC_STORE) begin
          ctrl.memrw = 1'b1;
          ctrl.pc_en = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        ctrl.regrw = 1'b1;
        ctrl.wb    = (iclass == IC_LOAD) ? WB_RAM : WB_ALU;
        ctrl.pc_en = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    // An instruction aborted by rst issues no side-effecting strobe.
    if (rst) begin
      ctrl.memrw = 1'b0;
      ctrl.regrw = 1'b0;
      ctrl.pc_en = 1'b0;
    end
  end

  assign pcsrc       = ctrl.pcsrc;
  assign alusrc      = ctrl.alusrc;
  assign memrw       = ctrl.memrw;
  assign wb          = ctrl.wb;
  assign regrw       = ctrl.regrw;
  assign aluop       = ctrl.aluop;
  assign immgen_ctrl = ctrl.immgen_ctrl;
  assign pc_en       = ctrl.pc_en;
  assign state       = state_q;
  assign trap        = (state_q == ST_TRAP);
  assign retired     = retired_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: directed instruction walks with literal expectations, then a
// random instruction/status/reset stream compared each cycle against a queue-based model.
module tb_ctrl_fsm;

  localparam int unsigned RW = 4;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00802283;
  localparam logic [31:0] I_SW  = 32'h00502623;
  localparam logic [31:0] I_BEQ = 32'h00000463;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  logic          clk;
  logic          rst;
  logic [31:0]   instr;
  logic [4:0]    status;
  logic          pcsrc, alusrc, memrw, wb, regrw;
  logic [3:0]    aluop;
  logic [1:0]    immgen_ctrl;
  logic          pc_en;
  logic [2:0]    state;
  logic          trap;
  logic [RW-1:0] retired;

  ctrl_fsm #(.RETIRE_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .status      (status),
    .pcsrc       (pcsrc),
    .alusrc      (alusrc),
    .memrw       (memrw),
    .wb          (wb),
    .regrw       (regrw),
    .aluop       (aluop),
    .immgen_ctrl (immgen_ctrl),
    .pc_en       (pc_en),
    .state       (state),
    .trap        (trap),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Reference model: current state code, remaining states of this instruction,
  // latched instruction and retired count.
  int          m_state = 0;
  int          m_rem[$];
  logic [31:0] m_ir    = '0;
  int          m_ret   = 0;
  int          alu_tab [8] = '{0, 5, 7, -1, 4, 6, 3, 2};

  function automatic int cls(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return -1;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] w);
    int c;
    int f3;
    c  = cls(w);
    f3 = int'(w[14:12]);
    if (c < 0) return 1'b0;
    if (c <= 1 && f3 == 3) return 1'b0;
    if (c == 4 && f3 > 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] sp(input logic [31:0] w, input logic [3:0] lo);
    return {^w, lo};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    case (k)
      0, 1: w[6:0] = 7'b0110011;
      2, 3: w[6:0] = 7'b0010011;
      4, 5: w[6:0] = 7'b0000011;
      6:    w[6:0] = 7'b0100011;
      7, 8: begin
        w[6:0] = 7'b1100011;
        if ($urandom_range(0, 7) != 0) w[14:13] = 2'b00;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] w, input logic [4:0] s, input logic r);
    @(posedge clk);
    #2;
    instr  = w;
    status = s;
    rst    = r;
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, then advance the model to the next edge.
  initial begin : compare
    int          c, f3;
    bit          act, last, ok;
    logic        e_src, e_mem, e_wb, e_reg, e_psrc, e_pc;
    logic [1:0]  e_imm;
    int          e_alu;
    logic [19:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        c     = cls(m_ir);
        f3    = int'(m_ir[14:12]);
        act   = (m_state >= 2) && (m_state <= 4);
        last  = act && (m_rem.size() == 0);
        e_src = 1'b0;
        e_imm = 2'b00;
        e_alu = 0;
        if (act) begin
          e_src = (c == 0 || c == 4);
          e_imm = (c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
          if (c >= 2) e_alu = (c == 4) ? 1 : 0;
          else e_alu = (f3 == 0 && c == 0 && m_ir[30]) ? 1 : alu_tab[f3];
        end
        e_pc   = last && !rst;
        e_mem  = (m_state == 3) && (c == 3) && !rst;
        e_reg  = (m_state == 4) && !rst;
        e_wb   = (m_state == 4) && (c == 0 || c == 1);
        e_psrc = (m_state == 2) && (c == 4) && ((f3 == 0) ? status[0] : !status[0]);
        exp_v  = {3'(m_state), (m_state == 5), e_psrc, e_src, e_mem, e_wb, e_reg,
                  4'(e_alu), e_imm, e_pc, RW'(m_ret)};
        got_v  = {state, trap, pcsrc, alusrc, memrw, wb, regrw, aluop, immgen_ctrl, pc_en, retired};
        n_checks++;
        if (got_v !== exp_v) begin
          n_errors++;
          $display("FAIL cycle_compare t=%0t got=%05h exp=%05h ir=%08h", $time, got_v, exp_v, m_ir);
        end

        if (rst) begin
          m_state = 0;
          m_ir    = '0;
          m_ret   = 0;
          m_rem.delete();
        end else begin
          if (e_pc) m_ret = (m_ret + 1) % (1 << RW);
          if (m_state == 0) begin
            m_ir    = instr;
            m_state = 1;
          end else if (m_state == 1) begin
            ok = legal(m_ir);
`ifdef CTRL_PARITY_CHECK_EN
            ok = ok && ((^m_ir) == status[4]);
`endif
            if (ok) begin
              case (c)
                0, 1:    m_rem = '{2, 4};
                2:       m_rem = '{2, 3, 4};
                3:       m_rem = '{2, 3};
                default: m_rem = '{2};
              endcase
              m_state = m_rem.pop_front();
            end else begin
              m_state = 5;
            end
          end else if (m_state != 5) begin
            m_state = (m_rem.size() == 0) ? 0 : m_rem.pop_front();
          end
        end
      end
    end
  end

  initial begin : stim
    int trap_run;
    rst    = 1'b1;
    instr  = '0;
    status = '0;
    @(posedge clk);
    #2;
    chk_on = 1'b1;
    cyc(I_ADD, sp(I_ADD, 4'h0), 1'b1);

    // Reset state, then add: 0,1,2,4,0
    cyc(I_ADD, sp(I_ADD, 4'h0), 1'b0);
    chk("rst_state", state, 0);
    chk("rst_trap", trap, 0);
    chk("rst_retired", retired, 0);
    chk("rst_ctrl", {pcsrc, alusrc, memrw, wb, regrw, aluop, immgen_ctrl, pc_en}, 0);
    cyc(I_ADD, sp(I_ADD, 4'h0), 1'b0);
    chk("add_decode", state, 1);
    cyc(I_ADD, sp(I_ADD, 4'h0), 1'b0);
    chk("add_exec", state, 2);
    cyc(I_ADD, sp(I_ADD, 4'h0), 1'b0);
    chk("add_wb_state", state, 4);
    chk("add_wb_ctrl", {regrw, wb, alusrc, aluop, pc_en}, 8'b1110_0001);
    chk("add_wb_retired", retired, 0);

    // lw: 0,1,2,3,4
    cyc(I_LW, sp(I_LW, 4'h0), 1'b0);
    chk("add_done_state", state, 0);
    chk("add_done_retired", retired, 1);
    cyc(I_LW, sp(I_LW, 4'h0), 1'b0);
    chk("lw_decode", state, 1);
    cyc(I_LW, sp(I_LW, 4'h0), 1'b0);
    chk("lw_exec", {state, alusrc, immgen_ctrl, aluop}, {3'd2, 1'b0, 2'b00, 4'd0});
    cyc(I_LW, sp(I_LW, 4'h0), 1'b0);
    chk("lw_mem", {state, memrw, regrw, pc_en}, {3'd3, 3'b000});
    cyc(I_LW, sp(I_LW, 4'h0), 1'b0);
    chk("lw_wb", {state, wb, regrw, pc_en, alusrc, immgen_ctrl}, {3'd4, 3'b011, 1'b0, 2'b00});

    // sw: 0,1,2,3 with memrw only in MEM
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("lw_done", {state, retired}, {3'd0, 4'd2});
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("sw_decode", {state, memrw, regrw}, {3'd1, 2'b00});
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("sw_exec", {state, memrw, regrw, immgen_ctrl}, {3'd2, 2'b00, 2'b01});
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("sw_mem", {state, memrw, regrw, pc_en, immgen_ctrl}, {3'd3, 3'b101, 2'b01});

    // beq taken (zero=1) then not taken (zero=0)
    cyc(I_BEQ, sp(I_BEQ, 4'h1), 1'b0);
    chk("sw_done", {state, memrw, regrw, retired}, {3'd0, 2'b00, 4'd3});
    cyc(I_BEQ, sp(I_BEQ, 4'h1), 1'b0);
    cyc(I_BEQ, sp(I_BEQ, 4'h1), 1'b0);
    chk("beq_taken", {state, pcsrc, pc_en}, {3'd2, 2'b11});
    cyc(I_BEQ, sp(I_BEQ, 4'h0), 1'b0);
    cyc(I_BEQ, sp(I_BEQ, 4'h0), 1'b0);
    cyc(I_BEQ, sp(I_BEQ, 4'h0), 1'b0);
    chk("beq_not_taken", {state, pcsrc, pc_en}, {3'd2, 2'b01});

    // Illegal opcode: sticky trap until rst
    cyc(I_BAD, sp(I_BAD, 4'h0), 1'b0);
    chk("bad_fetch", {state, retired}, {3'd0, 4'd5});
    cyc(I_BAD, sp(I_BAD, 4'h0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(I_BAD, sp(I_BAD, 4'h1), 1'b0);
      chk("trap_hold", {state, trap, pc_en, memrw, regrw}, {3'd5, 4'b1000});
    end
    cyc(I_SW, sp(I_SW, 4'h0), 1'b1);
    chk("trap_in_rst", {state, trap}, {3'd5, 1'b1});
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("trap_cleared", {state, trap, retired}, {3'd0, 1'b0, 4'd0});

    // sw aborted by rst during MEM
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("abort_exec", state, 2);
    cyc(I_SW, sp(I_SW, 4'h0), 1'b1);
    chk("abort_mem", {state, retired}, {3'd3, 4'd0});
    cyc(I_SW, sp(I_SW, 4'h0), 1'b0);
    chk("abort_after", {state, memrw, regrw, pc_en, retired}, {3'd0, 3'b000, 4'd0});

    // Random stream; long traps are escaped with rst
    trap_run = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] w;
      logic [4:0]  s;
      logic        r;
      w = rnd_instr();
      s = 5'($urandom());
`ifdef CTRL_PARITY_CHECK_EN
      s[4] = ($urandom_range(0, 15) == 0) ? ~(^m_ir) : (^m_ir);
`endif
      r = ($urandom_range(0, 59) == 0) || (trap_run > 6);
      cyc(w, s, r);
      trap_run = (m_state == 5) ? trap_run + 1 : 0;
    end

    @(posedge clk);
    #2;
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
